// File: rtl/adjacency_counter.sv
// Snapshots a mine map on start and walks the board one tile per clock, writing each tile's
// 4-bit adjacency code (F = mine, else neighbour mine count), then pulses done.
module adjacency_counter #(
  parameter int GRID_SIZE   = 8,
  parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
  parameter int IDX_BITS    = $clog2(TOTAL_TILES),
  parameter int CNT_BITS    = $clog2(TOTAL_TILES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TOTAL_TILES-1:0]   mine_map,
  output logic [TOTAL_TILES*4-1:0] adj,
  output logic [CNT_BITS-1:0]      mine_count,
  output logic                     busy,
  output logic                     done
);

  localparam int RC_BITS = $clog2(GRID_SIZE);
  localparam logic [RC_BITS-1:0]  LAST_RC  = RC_BITS'(GRID_SIZE - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(TOTAL_TILES - 1);
  localparam logic [IDX_BITS-1:0] G_IDX    = IDX_BITS'(GRID_SIZE);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t                 state, state_next;
  logic [TOTAL_TILES-1:0] snap;
  logic [RC_BITS-1:0]     row, col;
  logic [IDX_BITS-1:0]    idx;
  logic                   load, scan_en, busy_next, done_next;
  logic                   up_ok, dn_ok, lf_ok, rt_ok;
  logic [7:0]             nbr;
  logic [3:0]             nbr_count, code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    scan_en    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = SCAN;
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx == LAST_IDX) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == SCAN);
    // done trails FIN by one edge so it appears TOTAL_TILES+1 edges after start
    done_next = (state == FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap       <= '0;
      row        <= '0;
      col        <= '0;
      idx        <= '0;
      mine_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (load) begin
        snap       <= mine_map;
        row        <= '0;
        col        <= '0;
        idx        <= '0;
        mine_count <= '0;
      end else if (scan_en) begin
        idx <= idx + 1'b1;
        if (col == LAST_RC) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (snap[idx]) mine_count <= mine_count + 1'b1;
      end
    end
  end

  // Edge flags gate every neighbour so indices never wrap across rows or the board
  always_comb begin
    up_ok  = (row != '0);
    dn_ok  = (row != LAST_RC);
    lf_ok  = (col != '0);
    rt_ok  = (col != LAST_RC);
    nbr[0] = (up_ok && lf_ok) ? snap[idx - G_IDX - 1'b1] : 1'b0;
    nbr[1] = up_ok            ? snap[idx - G_IDX]        : 1'b0;
    nbr[2] = (up_ok && rt_ok) ? snap[idx - G_IDX + 1'b1] : 1'b0;
    nbr[3] = lf_ok            ? snap[idx - 1'b1]         : 1'b0;
    nbr[4] = rt_ok            ? snap[idx + 1'b1]         : 1'b0;
    nbr[5] = (dn_ok && lf_ok) ? snap[idx + G_IDX - 1'b1] : 1'b0;
    nbr[6] = dn_ok            ? snap[idx + G_IDX]        : 1'b0;
    nbr[7] = (dn_ok && rt_ok) ? snap[idx + G_IDX + 1'b1] : 1'b0;
    nbr_count = '0;
    for (int n = 0; n < 8; n++) begin
      nbr_count = nbr_count + {3'b000, nbr[n]};
    end
    code = snap[idx] ? 4'hF : nbr_count;
  end

  for (genvar gi = 0; gi < TOTAL_TILES; gi++) begin : g_tile
    logic [3:0] tile;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     tile <= 4'h0;
      else if (load)                                tile <= 4'h0;
      else if (scan_en && idx == IDX_BITS'(gi))     tile <= code;
    end
    assign adj[4*gi +: 4] = tile;
  end

endmodule
